// File: rtl/gardner_ted_if.sv
// Sample, strobe and error/raw-delay signals between the DDC front end,
// the Gardner detector and its consumers.
interface gardner_ted_if #(
    parameter int WIQ  = 16,
    parameter int WERR = 18
);
    logic signed [WIQ-1:0]  i_in;
    logic signed [WIQ-1:0]  q_in;
    logic                   iq_val;
    logic                   sym_valid_i;
    logic signed [WERR-1:0] e_out_o;
    logic                   e_valid_o;
    logic signed [WIQ-1:0]  i_raw_delay_o;
    logic signed [WIQ-1:0]  q_raw_delay_o;

    modport master (
        output i_in, q_in, iq_val, sym_valid_i,
        input  e_out_o, e_valid_o, i_raw_delay_o, q_raw_delay_o
    );

    modport slave (
        input  i_in, q_in, iq_val, sym_valid_i,
        output e_out_o, e_valid_o, i_raw_delay_o, q_raw_delay_o
    );
endinterface

// File: rtl/gardner_ted.sv
// Gardner timing-error detector: e = M_I*(S_k,I - S_k-1,I) + M_Q*(S_k,Q - S_k-1,Q),
// three register stages from strobe to e_valid_o, plus a fixed raw I/Q delay tap.
module gardner_ted #(
    parameter int OSF     = 20,
    parameter int WIQ     = 16,
    parameter int WERR    = 18,
    parameter int RAW_DLY = OSF / 2
) (
    input  logic       clk,
    input  logic       reset_n,
    gardner_ted_if.slave bus
);
    localparam int MID = OSF / 2;
    localparam int CW  = $clog2(OSF + 1);
    localparam int DW  = WIQ + 1;
    localparam int PW  = 2 * WIQ + 1;
    localparam int SW  = 2 * WIQ + 2;

    logic signed [WIQ-1:0]  hist_i_r [0:OSF];
    logic signed [WIQ-1:0]  hist_q_r [0:OSF];
    logic signed [WIQ-1:0]  hist_i_s [0:OSF];
    logic signed [WIQ-1:0]  hist_q_s [0:OSF];
    logic [CW-1:0]          prime_cnt_r;
    logic signed [WIQ-1:0]  raw_i_r, raw_q_r;

    logic                   have_prev_r, armed_r, armed_s, prime_full_s;
    logic signed [WIQ-1:0]  prev_i_r, prev_q_r;
    logic signed [WIQ-1:0]  s_i_r, s_q_r, sp_i_r, sp_q_r, m_i_r, m_q_r;
    logic                   v1_r;

    logic signed [DW-1:0]   d_i_s, d_q_s;
    logic signed [PW-1:0]   p_i_s, p_q_s, p_i_r, p_q_r;
    logic                   v2_r;

    logic signed [SW-1:0]   sum_s;
    logic signed [WERR-1:0] e_s, e_out_r;
    logic                   e_valid_r;

    // Post-shift view of the history lines: the new sample lands in tap 0.
    always_comb begin
        hist_i_s[0] = bus.i_in;
        hist_q_s[0] = bus.q_in;
        for (int k = 1; k <= OSF; k++) begin
            hist_i_s[k] = hist_i_r[k-1];
            hist_q_s[k] = hist_q_r[k-1];
        end
    end

    // History shift, priming count and raw delay tap, all gated by iq_val.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= OSF; k++) begin
                hist_i_r[k] <= '0;
                hist_q_r[k] <= '0;
            end
            prime_cnt_r <= '0;
            raw_i_r     <= '0;
            raw_q_r     <= '0;
        end else if (bus.iq_val) begin
            for (int k = 0; k <= OSF; k++) begin
                hist_i_r[k] <= hist_i_s[k];
                hist_q_r[k] <= hist_q_s[k];
            end
            raw_i_r <= hist_i_s[RAW_DLY-1];
            raw_q_r <= hist_q_s[RAW_DLY-1];
            if (prime_cnt_r != CW'(OSF)) begin
                prime_cnt_r <= prime_cnt_r + CW'(1);
            end
        end
    end

    assign prime_full_s = (prime_cnt_r == CW'(OSF));
    assign armed_s      = armed_r | (prime_full_s & have_prev_r);

    // Strobe capture from pre-shift history; S_k-1 is the previous strobe's tap 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_prev_r <= 1'b0;
            armed_r     <= 1'b0;
            prev_i_r    <= '0;
            prev_q_r    <= '0;
            s_i_r       <= '0;
            s_q_r       <= '0;
            sp_i_r      <= '0;
            sp_q_r      <= '0;
            m_i_r       <= '0;
            m_q_r       <= '0;
            v1_r        <= 1'b0;
        end else begin
            v1_r <= bus.sym_valid_i & armed_s;
            if (bus.sym_valid_i) begin
                have_prev_r <= 1'b1;
                armed_r     <= armed_s;
                prev_i_r    <= hist_i_r[0];
                prev_q_r    <= hist_q_r[0];
                s_i_r       <= hist_i_r[0];
                s_q_r       <= hist_q_r[0];
                sp_i_r      <= prev_i_r;
                sp_q_r      <= prev_q_r;
                m_i_r       <= hist_i_r[MID];
                m_q_r       <= hist_q_r[MID];
            end
        end
    end

    assign d_i_s = DW'(s_i_r) - DW'(sp_i_r);
    assign d_q_s = DW'(s_q_r) - DW'(sp_q_r);
    assign p_i_s = PW'(m_i_r) * PW'(d_i_s);
    assign p_q_s = PW'(m_q_r) * PW'(d_q_s);
    assign sum_s = SW'(p_i_r) + SW'(p_q_r);

    generate
        if (WERR >= SW) begin : g_extend
            assign e_s = WERR'(sum_s);
        end else begin : g_shift
            assign e_s = WERR'(sum_s >>> (SW - WERR));
        end
    endgenerate

    // Product stage then output stage; e_out_r holds between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_i_r     <= '0;
            p_q_r     <= '0;
            v2_r      <= 1'b0;
            e_out_r   <= '0;
            e_valid_r <= 1'b0;
        end else begin
            p_i_r     <= p_i_s;
            p_q_r     <= p_q_s;
            v2_r      <= v1_r;
            e_valid_r <= v2_r;
            if (v2_r) begin
                e_out_r <= e_s;
            end
        end
    end

    assign bus.e_out_o       = e_out_r;
    assign bus.e_valid_o     = e_valid_r;
    assign bus.i_raw_delay_o = raw_i_r;
    assign bus.q_raw_delay_o = raw_q_r;
endmodule

// File: tb/tb_gardner_ted.sv
// Directed bench for gardner_ted: sample-list reference model checked every
// cycle, plus hand-computed error values for the known-error cases.
module tb_gardner_ted;
    localparam int OSF     = 20;
    localparam int WIQ     = 16;
    localparam int WERR    = 18;
    localparam int RAW_DLY = OSF / 2;
    localparam int SHIFT   = 2 * WIQ + 2 - WERR;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    gardner_ted_if #(.WIQ(WIQ), .WERR(WERR)) bus ();

    gardner_ted #(.OSF(OSF), .WIQ(WIQ), .WERR(WERR), .RAW_DLY(RAW_DLY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the list of every accepted sample since reset.
    int     acc_i[$];
    int     acc_q[$];
    bit     have_prev, armed;
    longint prev_i, prev_q;
    bit     d0_v, d1_v, exp_v;
    longint d0_e, d1_e, exp_e;
    longint exp_raw_i, exp_raw_q;

    function automatic longint smp_i(input int idx);
        return (idx >= 0 && idx < acc_i.size()) ? longint'(acc_i[idx]) : 64'sd0;
    endfunction

    function automatic longint smp_q(input int idx);
        return (idx >= 0 && idx < acc_q.size()) ? longint'(acc_q[idx]) : 64'sd0;
    endfunction

    function automatic longint to_werr(input longint v);
        logic signed [WERR-1:0] t;
        t = v[WERR-1:0];
        return longint'(t);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_e_valid", longint'(bus.e_valid_o), 0);
                check("rst_e_out", longint'(bus.e_out_o), 0);
                check("rst_raw_i", longint'(bus.i_raw_delay_o), 0);
                check("rst_raw_q", longint'(bus.q_raw_delay_o), 0);
                acc_i.delete();
                acc_q.delete();
                have_prev = 1'b0; armed = 1'b0; prev_i = 0; prev_q = 0;
                d0_v = 1'b0; d1_v = 1'b0; exp_v = 1'b0;
                d0_e = 0; d1_e = 0; exp_e = 0; exp_raw_i = 0; exp_raw_q = 0;
            end else begin
                bit     new_v;
                longint new_e, si, sq, mi, mq, sum;
                int     n;
                check("e_valid", longint'(bus.e_valid_o), longint'(exp_v));
                check("e_out", longint'(bus.e_out_o), exp_e);
                check("raw_i", longint'(bus.i_raw_delay_o), exp_raw_i);
                check("raw_q", longint'(bus.q_raw_delay_o), exp_raw_q);
                new_v = 1'b0;
                new_e = 0;
                if (bus.sym_valid_i) begin
                    n  = acc_i.size();
                    si = smp_i(n - 1);
                    sq = smp_q(n - 1);
                    mi = smp_i(n - 1 - OSF / 2);
                    mq = smp_q(n - 1 - OSF / 2);
                    armed = armed || (n >= OSF && have_prev);
                    if (armed) begin
                        sum   = mi * (si - prev_i) + mq * (sq - prev_q);
                        new_v = 1'b1;
                        new_e = to_werr(sum >>> SHIFT);
                    end
                    prev_i = si;
                    prev_q = sq;
                    have_prev = 1'b1;
                end
                if (bus.iq_val) begin
                    acc_i.push_back(int'(bus.i_in));
                    acc_q.push_back(int'(bus.q_in));
                    exp_raw_i = smp_i(acc_i.size() - RAW_DLY);
                    exp_raw_q = smp_q(acc_q.size() - RAW_DLY);
                end
                if (d1_v) exp_e = d1_e;
                exp_v = d1_v;
                d1_v = d0_v; d1_e = d0_e;
                d0_v = new_v; d0_e = new_e;
            end
        end
    end

    task automatic cyc(input bit v, input bit s, input int i, input int q);
        bus.iq_val      = v;
        bus.sym_valid_i = s;
        bus.i_in        = i[WIQ-1:0];
        bus.q_in        = q[WIQ-1:0];
        @(posedge clk);
        #1;
        bus.iq_val      = 1'b0;
        bus.sym_valid_i = 1'b0;
    endtask

    task automatic expect_pulse(input string name, input longint exp);
        bit found = 1'b0;
        int lat = -1;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (bus.e_valid_o) begin
                found = 1'b1;
                lat   = k;
                check(name, longint'(bus.e_out_o), exp);
            end
        end
        check({name, "_seen"}, longint'(found), 1);
        check({name, "_latency"}, longint'(lat), 2);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_none(input string name);
        int cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.e_valid_o) cnt++;
        end
        check(name, longint'(cnt), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("async_e_out", longint'(bus.e_out_o), 0);
        check("async_e_valid", longint'(bus.e_valid_o), 0);
        check("async_raw_i", longint'(bus.i_raw_delay_o), 0);
        check("async_raw_q", longint'(bus.q_raw_delay_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // prev loaded by a strobe, then mid and strobe sample OSF/2 apart.
    task automatic pattern(input string name, input int pv, input int mv, input int sv,
                           input bit on_i, input bit on_q, input longint exp);
        cyc(1'b1, 1'b0, on_i ? pv : 0, on_q ? pv : 0);
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b1, 1'b0, on_i ? mv : 0, on_q ? mv : 0);
        for (int k = 0; k < OSF / 2 - 1; k++) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, on_i ? sv : 0, on_q ? sv : 0);
        cyc(1'b0, 1'b1, 0, 0);
        expect_pulse(name, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.i_in = '0; bus.q_in = '0; bus.iq_val = 1'b0; bus.sym_valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Constant input: first strobe unarmed, later strobes give zero error.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < OSF; k++) cyc(1'b1, k == OSF - 1, 1000, -500);
            if (r == 0) expect_none("const_first_strobe");
            else        expect_pulse("const_zero", 0);
        end

        // Known error values on I, Q and both.
        do_reset();
        for (int k = 0; k < OSF; k++) cyc(1'b1, 1'b0, 0, 0);
        pattern("known_i_pos", -8192,  4096, 8192, 1'b1, 1'b0, 1024);
        pattern("known_i_neg", -8192, -4096, 8192, 1'b1, 1'b0, -1024);
        pattern("known_q",     -8192,  4096, 8192, 1'b0, 1'b1, 1024);
        pattern("known_iq",    -8192,  4096, 8192, 1'b1, 1'b1, 2048);

        // Strobe coinciding with iq_val uses pre-shift taps; then back-to-back strobe.
        cyc(1'b1, 1'b0, -8192, 0);
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b1, 1'b0, 2048, 0);
        for (int k = 0; k < OSF / 2 - 1; k++) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 8192, 0);
        cyc(1'b1, 1'b1, -8192, 0);
        cyc(1'b0, 1'b1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("simul_valid", longint'(bus.e_valid_o), 1);
        check("simul_e_out", longint'(bus.e_out_o), 512);
        @(negedge clk);
        check("b2b_valid", longint'(bus.e_valid_o), 1);
        check("b2b_e_out", longint'(bus.e_out_o), 0);
        @(posedge clk);
        #1;

        // Raw delay: ramp with iq_val every other cycle; stalled input must not shift.
        do_reset();
        for (int v = 0; v < 40; v++) begin
            cyc(1'b1, 1'b0, v, v + 100);
            bus.i_in = WIQ'(v + 1);
            bus.q_in = WIQ'(v + 101);
            @(negedge clk);
            check("ramp_raw_i", longint'(bus.i_raw_delay_o), (v >= RAW_DLY - 1) ? v - 9 : 0);
            check("ramp_raw_q", longint'(bus.q_raw_delay_o), (v >= RAW_DLY - 1) ? v + 91 : 0);
            @(posedge clk);
            #1;
        end

        // Reset with an error in flight: no pulse afterwards, priming restarts.
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, 0, 0);
        do_reset();
        expect_none("reset_kill");
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 300, 300);
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, 0, 0);
        expect_none("reprime_short");
        for (int k = 0; k < OSF; k++) cyc(1'b1, 1'b0, 300, 300);
        cyc(1'b0, 1'b1, 0, 0);
        expect_pulse("reprime_armed", 0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
